// File: rtl/fifo_uart_param_if.sv
// fifo_uart_param_if: handshake/status bundle for fifo_uart_param.
//   master modport: drives flush, wrreq, data, rdreq, err_clr; observes all status and q.
//   slave modport : the FIFO side, mirror image of master.
// Instantiate with the same WIDTH/DEPTH as the FIFO it connects to.
interface fifo_uart_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic             flush;
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             rdreq;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      usedw;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wrreq, data, rdreq, err_clr,
    input  q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  flush, wrreq, data, rdreq, err_clr,
    output q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );
endinterface

// File: rtl/fifo_uart_param.sv
// fifo_uart_param: synchronous single-clock FIFO with status flags and sticky error bits.
//   clock : sole clock, rising edge.
//   sclr  : asynchronous active-high reset.
//   bus   : fifo_uart_param_if.slave (flush, wrreq, data, rdreq, err_clr in;
//           q, full, empty, almost_full, almost_empty, usedw, overflow, underflow out).
// Build option: define FIFO_UART_PARAM_SHOWAHEAD_EN for a zero-latency show-ahead q;
// otherwise q is a register loaded on each accepted read.
// DEPTH must be a power of two, at least 4.
module fifo_uart_param #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_LVL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input logic              clock,
  input logic              sclr,
  fifo_uart_param_if.slave bus
);

  localparam logic [AW:0] AfullThr  = AFULL_LVL[AW:0];
  localparam logic [AW:0] AemptyThr = AEMPTY_LVL[AW:0];

  // Storage is deliberately left out of reset.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit above the AW index bits.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_usedw;
  logic        r_overflow;
  logic        r_underflow;

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Status comes from registered pointers only, never from the requests.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

  // flush masks both requests for its cycle.
  assign w_wr_acc = bus.wrreq & ~w_full  & ~bus.flush;
  assign w_rd_acc = bus.rdreq & ~w_empty & ~bus.flush;

  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[w_wr_idx] <= bus.data;
    end
  end

  // Power-of-two depth: a plain +1 carries into the wrap bit on DEPTH-1 -> 0.
  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_usedw <= r_usedw + 1'b1;
        2'b01:   r_usedw <= r_usedw - 1'b1;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

  // Sticky errors: the set term comes last so it beats err_clr in the same cycle.
  // Requests are ignored during flush, so flush cannot raise an error.
  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (!bus.flush && bus.wrreq && w_full) begin
        r_overflow <= 1'b1;
      end
      if (!bus.flush && bus.rdreq && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_UART_PARAM_SHOWAHEAD_EN
  // Head entry is presented directly; valid whenever empty is low.
  assign bus.q = r_mem[w_rd_idx];
`else
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_q <= '0;
    end else if (w_rd_acc) begin
      r_q <= r_mem[w_rd_idx];
    end
  end

  assign bus.q = r_q;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.usedw        = r_usedw;
  assign bus.almost_full  = (r_usedw >= AfullThr);
  assign bus.almost_empty = (r_usedw <= AemptyThr);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_uart_param.sv
// tb_fifo_uart_param: scoreboard bench for fifo_uart_param (DEPTH 16, WIDTH 8, thresholds 14/2).
// Works in either q mode; FIFO_UART_PARAM_SHOWAHEAD_EN selects the expectation for q.
module tb_fifo_uart_param;
  localparam int unsigned Depth = 16;

  logic clock;
  logic sclr;

  fifo_uart_param_if #(.WIDTH(8), .DEPTH(Depth)) bus ();

  fifo_uart_param #(
    .WIDTH     (8),
    .DEPTH     (Depth),
    .AFULL_LVL (14),
    .AEMPTY_LVL(2)
  ) u_dut (
    .clock(clock),
    .sclr (sclr),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] sb[$];
  int         m_cnt = 0;
  logic       m_ov  = 1'b0;
  logic       m_un  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".usedw"}, 32'(bus.usedw), 32'(m_cnt));
    check({tag, ".full"},  32'(bus.full),  32'(m_cnt == Depth));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_cnt == 0));
    check({tag, ".afull"}, 32'(bus.almost_full),  32'(m_cnt >= 14));
    check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(m_cnt <= 2));
    check({tag, ".ovf"},   32'(bus.overflow),  32'(m_ov));
    check({tag, ".unf"},   32'(bus.underflow), 32'(m_un));
  endtask

  // One clock: drive at post-edge +1, sample at next post-edge +1.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd,
                     input logic fl = 1'b0, input logic ec = 1'b0);
    logic       wa;
    logic       ra;
    logic [7:0] exp_q;
    bus.wrreq   = wr;
    bus.data    = d;
    bus.rdreq   = rd;
    bus.flush   = fl;
    bus.err_clr = ec;
    wa = wr && !fl && (m_cnt < Depth);
    ra = rd && !fl && (m_cnt > 0);
`ifdef FIFO_UART_PARAM_SHOWAHEAD_EN
    if (ra) begin
      #1;
      check("q_ahead", 32'(bus.q), 32'(sb[0]));
    end
`endif
    if (ec) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (wr && !fl && m_cnt == Depth) m_ov = 1'b1;
    if (rd && !fl && m_cnt == 0)     m_un = 1'b1;
    @(posedge clock);
    #1;
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (ra) begin
        exp_q = sb.pop_front();
        m_cnt--;
`ifndef FIFO_UART_PARAM_SHOWAHEAD_EN
        check("q_reg", 32'(bus.q), 32'(exp_q));
`endif
      end
      if (wa) begin
        sb.push_back(d);
        m_cnt++;
      end
    end
    check_status("cyc");
    bus.wrreq   = 1'b0;
    bus.rdreq   = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".usedw"},  32'(bus.usedw), 32'd0);
    check({tag, ".empty"},  32'(bus.empty), 32'd1);
    check({tag, ".full"},   32'(bus.full),  32'd0);
    check({tag, ".aempty"}, 32'(bus.almost_empty), 32'd1);
    check({tag, ".afull"},  32'(bus.almost_full),  32'd0);
    check({tag, ".ovf"},    32'(bus.overflow),  32'd0);
    check({tag, ".unf"},    32'(bus.underflow), 32'd0);
`ifndef FIFO_UART_PARAM_SHOWAHEAD_EN
    check({tag, ".q"},      32'(bus.q), 32'd0);
`endif
  endtask

  initial begin
    sclr        = 1'b1;
    bus.wrreq   = 1'b0;
    bus.rdreq   = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.data    = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("reset");
    sclr = 1'b0;

    // Fill 0x11..0x1F then 0x10; 17th write must overflow and be dropped.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'h10 + 8'(i % 16), 1'b0);
    end
    check("fill_full", 32'(bus.full), 32'd1);
`ifdef FIFO_UART_PARAM_SHOWAHEAD_EN
    check("ahead_idle_q", 32'(bus.q), 32'h11);
`else
    check("reg_idle_q", 32'(bus.q), 32'h00);
`endif
    cyc(1'b1, 8'hAA, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);

    // Drain all 16; order checked by the scoreboard.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    check("unf_set", 32'(bus.underflow), 32'd1);

    // Empty with both requests: write only, usedw becomes 1.
    cyc(1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    // Set event beats err_clr, then a bare err_clr clears both.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("err_clr", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Hold 8, then 40 cycles of simultaneous read and write across the wrap.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'h80 + 8'(i), 1'b1);
    end
    check("pass_usedw", 32'(bus.usedw), 32'd8);

    // Down to 5, then flush alongside a write that must be dropped.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("pre_flush", 32'(bus.usedw), 32'd5);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    check("flush_empty", 32'(bus.empty), 32'd1);
    cyc(1'b1, 8'h21, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // Async reset mid-burst, observed before the next edge.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    bus.wrreq = 1'b1;
    bus.data  = 8'h99;
    #2;
    sclr = 1'b1;
    #1;
    check_reset_vals("async_rst");
    bus.wrreq = 1'b0;
    sb.delete();
    m_cnt = 0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
    @(posedge clock);
    #1;
    check_reset_vals("rst_held");
    sclr = 1'b0;
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
